// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, default datapath width
// and the two-state output-register control encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_NAND = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_ANDN = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } lu_state_e;

endpackage

// File: rtl/logic_unit_reg_if.sv
// Operand/result handshake bundle between operand decode,
// the logic unit and the ALU result mux.
interface logic_unit_reg_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_e          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ones;
  logic             parity;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y,
    input  zero, ones, parity, done_cnt
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y,
    output zero, ones, parity, done_cnt
  );

endinterface

// File: rtl/logic_unit_reg_core.sv
// Combinational bitwise op select plus result flags;
// no inter-bit dependency, so any WIDTH works unchanged.
module logic_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o,
  output logic             ones_o,
  output logic             parity_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_NAND: y_o = ~(a_i & b_i);
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_NOTA: y_o = ~a_i;
      OP_ANDN: y_o = a_i & ~b_i;
      default: y_o = '0;
    endcase
  end

  assign zero_o   = ~|y_o;
  assign ones_o   = &y_o;
  assign parity_o = ^y_o;

endmodule

// File: rtl/logic_unit_reg.sv
// Registered bitwise logic unit: one-deep result register
// behind a valid/ready handshake, plus a delivered-result count.
module logic_unit_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  logic_unit_reg_if.slave bus
);

  lu_state_e        state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             deliver;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .op_i     (bus.op),
    .y_o      (y_d),
    .zero_o   (zero_d),
    .ones_o   (ones_d),
    .parity_o (par_d)
  );

  // in_ready looks only at state and out_ready
  assign bus.in_ready = (state_q == ST_EMPTY) || bus.out_ready;
  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = (state_q == ST_FULL) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (deliver && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == ST_FULL);
    bus.y         = y_q;
    bus.zero      = zero_q;
    bus.ones      = ones_q;
    bus.parity    = par_q;
    bus.done_cnt  = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      zero_q <= 1'b1;
      ones_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (accept) begin
      y_q    <= y_d;
      zero_q <= zero_d;
      ones_q <= ones_d;
      par_q  <= par_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (deliver) cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_logic_unit_reg.sv
// Directed bench: WIDTH 8/1/64 instances, op table,
// backpressure, counter wrap and asynchronous reset mid-stall.
module tb_logic_unit_reg;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic_unit_reg_if #(.WIDTH(8),  .CNT_W(16)) b8 ();
  logic_unit_reg_if #(.WIDTH(1),  .CNT_W(2))  b1 ();
  logic_unit_reg_if #(.WIDTH(64), .CNT_W(16)) b64 ();

  logic_unit_reg #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8));
  logic_unit_reg #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  logic_unit_reg #(.WIDTH(64), .CNT_W(16)) u64 (
    .clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct {
    alu_op_e    op;
    logic [7:0] a, b, y;
    logic       z, o, p;
  } vec8_t;

  typedef struct {
    alu_op_e op;
    logic    a, b, y;
    logic [1:0] cnt;
  } vec1_t;

  vec8_t v8[11];
  vec1_t v1[5];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt0;
    v8[0]  = '{OP_NAND, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0, 1'b0};
    v8[1]  = '{OP_AND,  8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0, 1'b0};
    v8[2]  = '{OP_OR,   8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0, 1'b0};
    v8[3]  = '{OP_NOR,  8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0, 1'b0};
    v8[4]  = '{OP_XOR,  8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0, 1'b0};
    v8[5]  = '{OP_XNOR, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0, 1'b0};
    v8[6]  = '{OP_NOTA, 8'hF0, 8'hCC, 8'h0F, 1'b0, 1'b0, 1'b0};
    v8[7]  = '{OP_ANDN, 8'hF0, 8'hCC, 8'h30, 1'b0, 1'b0, 1'b0};
    v8[8]  = '{OP_AND,  8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0};
    v8[9]  = '{OP_OR,   8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
    v8[10] = '{OP_XOR,  8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};

    v1[0] = '{OP_NAND, 1'b0, 1'b0, 1'b1, 2'd0};
    v1[1] = '{OP_NAND, 1'b0, 1'b1, 1'b1, 2'd1};
    v1[2] = '{OP_NAND, 1'b1, 1'b0, 1'b1, 2'd2};
    v1[3] = '{OP_NAND, 1'b1, 1'b1, 1'b0, 2'd3};
    v1[4] = '{OP_AND,  1'b1, 1'b1, 1'b1, 2'd0};

    b8.in_valid = 0; b8.a = '0; b8.b = '0;
    b8.op = OP_NAND; b8.out_ready = 1;
    b1.in_valid = 0; b1.a = '0; b1.b = '0;
    b1.op = OP_NAND; b1.out_ready = 1;
    b64.in_valid = 0; b64.a = '0; b64.b = '0;
    b64.op = OP_NAND; b64.out_ready = 1;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_out_valid", 64'(b8.out_valid), 64'd0);
    check("rst_y", 64'(b8.y), 64'h0);
    check("rst_zero", 64'(b8.zero), 64'd1);
    check("rst_ones", 64'(b8.ones), 64'd0);
    check("rst_parity", 64'(b8.parity), 64'd0);
    check("rst_done_cnt", 64'(b8.done_cnt), 64'd0);
    check("rst_in_ready", 64'(b8.in_ready), 64'd1);

    // back-to-back table, out_ready held high
    for (int i = 0; i < 11; i++) begin
      b8.in_valid = 1; b8.op = v8[i].op;
      b8.a = v8[i].a; b8.b = v8[i].b;
      step();
      check($sformatf("w8_valid[%0d]", i), 64'(b8.out_valid), 64'd1);
      check($sformatf("w8_y[%0d]", i), 64'(b8.y), 64'(v8[i].y));
      check($sformatf("w8_zero[%0d]", i), 64'(b8.zero), 64'(v8[i].z));
      check($sformatf("w8_ones[%0d]", i), 64'(b8.ones), 64'(v8[i].o));
      check($sformatf("w8_par[%0d]", i), 64'(b8.parity), 64'(v8[i].p));
      check($sformatf("w8_cnt[%0d]", i), 64'(b8.done_cnt), 64'(i));
    end
    b8.in_valid = 0;
    step();
    check("w8_drain_valid", 64'(b8.out_valid), 64'd0);
    check("w8_drain_cnt", 64'(b8.done_cnt), 64'd11);
    check("w8_drain_hold_y", 64'(b8.y), 64'h01);

    // backpressure
    b8.in_valid = 1; b8.op = OP_AND;
    b8.a = 8'hAA; b8.b = 8'h0F;
    step();
    check("bp_first_y", 64'(b8.y), 64'h0A);
    cnt0 = int'(b8.done_cnt);
    b8.out_ready = 0; b8.op = OP_OR; b8.b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      b8.a = 8'(i * 16 + 3);
      #1;
      check($sformatf("bp_in_ready[%0d]", i), 64'(b8.in_ready), 64'd0);
      step();
      check($sformatf("bp_valid[%0d]", i), 64'(b8.out_valid), 64'd1);
      check($sformatf("bp_y[%0d]", i), 64'(b8.y), 64'h0A);
      check($sformatf("bp_zero[%0d]", i), 64'(b8.zero), 64'd0);
      check($sformatf("bp_par[%0d]", i), 64'(b8.parity), 64'd0);
      check($sformatf("bp_cnt[%0d]", i), 64'(b8.done_cnt), 64'(cnt0));
    end
    b8.out_ready = 1; b8.op = OP_XOR;
    b8.a = 8'h55; b8.b = 8'hFF;
    #1;
    check("bp_release_ready", 64'(b8.in_ready), 64'd1);
    step();
    check("bp_new_y", 64'(b8.y), 64'hAA);
    check("bp_new_valid", 64'(b8.out_valid), 64'd1);
    check("bp_cnt_once", 64'(b8.done_cnt), 64'(cnt0 + 1));
    b8.in_valid = 0;
    step();
    check("bp_empty", 64'(b8.out_valid), 64'd0);
    check("bp_cnt_final", 64'(b8.done_cnt), 64'(cnt0 + 2));
    check("bp_hold_y", 64'(b8.y), 64'hAA);
    step();
    check("bp_cnt_idle", 64'(b8.done_cnt), 64'(cnt0 + 2));

    // WIDTH=1 NAND exhaustive plus CNT_W=2 wrap
    for (int i = 0; i < 5; i++) begin
      b1.in_valid = 1; b1.op = v1[i].op;
      b1.a = v1[i].a; b1.b = v1[i].b;
      step();
      check($sformatf("w1_y[%0d]", i), 64'(b1.y), 64'(v1[i].y));
      check($sformatf("w1_cnt[%0d]", i), 64'(b1.done_cnt), 64'(v1[i].cnt));
    end
    b1.in_valid = 0;
    step();
    check("w1_cnt_wrap", 64'(b1.done_cnt), 64'd1);

    // WIDTH=64
    b64.in_valid = 1; b64.op = OP_NAND;
    b64.a = '1; b64.b = '1;
    step();
    check("w64_nand_y", b64.y, 64'h0);
    check("w64_nand_zero", 64'(b64.zero), 64'd1);
    b64.op = OP_AND;
    step();
    check("w64_and_y", b64.y, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_and_ones", 64'(b64.ones), 64'd1);
    check("w64_and_par", 64'(b64.parity), 64'd0);
    b64.in_valid = 0;
    step();

    // asynchronous reset during a stall
    b8.in_valid = 1; b8.op = OP_OR;
    b8.a = 8'h12; b8.b = 8'h34;
    b8.out_ready = 0;
    step();
    check("rs_pre_y", 64'(b8.y), 64'h36);
    check("rs_pre_valid", 64'(b8.out_valid), 64'd1);
    b8.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", 64'(b8.out_valid), 64'd0);
    check("rs_y", 64'(b8.y), 64'h0);
    check("rs_cnt", 64'(b8.done_cnt), 64'd0);
    check("rs_in_ready", 64'(b8.in_ready), 64'd1);
    rst_n = 1'b1;
    step();
    check("rs_idle_valid", 64'(b8.out_valid), 64'd0);
    b8.in_valid = 1; b8.op = OP_XOR;
    b8.a = 8'h0F; b8.b = 8'hF0;
    step();
    check("rs_post_y", 64'(b8.y), 64'hFF);
    check("rs_post_ones", 64'(b8.ones), 64'd1);
    b8.in_valid = 0; b8.out_ready = 1;
    step();
    check("rs_post_cnt", 64'(b8.done_cnt), 64'd1);
    check("rs_post_empty", 64'(b8.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_reg.md
# logic_unit_reg

Parametrised, registered bitwise logic unit: the WIDTH-bit, multi-operation successor of the 1-bit NAND cell and the logic half of the integer ALU. It accepts operand pairs over a valid/ready handshake and returns the selected bitwise result plus status flags from an output register one cycle later. It also keeps a wrapping count of completed results. It sits between the ALU operand-decode stage and the ALU result mux.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits; legal range is 1 to 64.
- CNT_W, 16: width of the completed-result counter.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operands and op are valid this cycle.
- in_ready, output, 1: the block can accept an operation this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- op, input, 3: operation select (see Operation).
- out_valid, output, 1: the result register holds an undelivered result.
- out_ready, input, 1: the consumer accepts the result this cycle.
- y, output, WIDTH: registered result.
- zero, output, 1: registered; y == 0.
- ones, output, 1: registered; y is all ones.
- parity, output, 1: registered; XOR-reduction of y (1 = odd number of ones).
- done_cnt, output, CNT_W: number of results delivered, wrapping.

## Operation
- op encoding: 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a (b ignored), 111 ANDN (a & ~b).
- All operations are per-bit; there is no carry and no inter-bit dependency.
- Flags are computed from the new result and captured in the same edge as y.
- Accept: in_valid && in_ready.
- Deliver: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This combinational pass-through gives full throughput under continuous out_ready.
- On accept: y, zero, ones and parity load the new values, and out_valid is 1 next cycle.
- On deliver without accept: out_valid goes to 0. y and the flags hold their last values.
- On simultaneous deliver and accept: the register is overwritten and out_valid stays 1.
- While out_valid && !out_ready: y, the flags and out_valid hold stable. in_ready is 0, and inputs are ignored even if in_valid is 1.
- done_cnt increments by 1 on each deliver and wraps from 2^CNT_W-1 to 0.
- Reset: out_valid = 0, y = 0, zero = 1, ones = 0, parity = 0, done_cnt = 0. in_ready therefore reads 1.
- Reset asserted mid-transaction discards the pending result and does not count it.

## Timing
- Latency: 1 cycle from accept to out_valid/y.
- Throughput: 1 result per cycle while out_ready = 1.
- Two-state control (EMPTY / FULL), encoded by out_valid:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on deliver without accept.
  - FULL to FULL on deliver with accept, or on stall.
- Outputs must not glitch during a stall.
- in_ready depends combinationally on out_ready only; there is no path from a, b or op to any output.
- done_cnt is registered and updates on the edge that completes a deliver.

## Structure
- Shared package alu_pkg holds:
  - the 3-bit op type and its eight named constants;
  - the default WIDTH constant, to be reused by the arithmetic unit and the result mux.
- One sub-module: logic_core.
  - Purely combinational: (a, b, op) in; y_next, zero_next, ones_next, parity_next out.
  - Instantiated once; the top holds the handshake, result register and counter.
- The 1-bit NAND cell is not instantiated; logic_core uses behavioural bitwise operators.

## Test plan
- Reset, then WIDTH = 8, a = 8'hF0, b = 8'hCC, out_ready = 1, all eight ops back-to-back. Each result appears exactly 1 cycle after its accept:
  - NAND 3F, AND C0, OR FC, NOR 03, XOR 3C, XNOR C3, NOT a 0F, ANDN 30.
  - done_cnt reads 8 after the last deliver.
- Flags: AND of 8'h0F with 8'hF0 gives y = 00, zero = 1, ones = 0, parity = 0. OR of 8'hFF with 8'h00 gives y = FF, ones = 1, zero = 0, parity = 0. XOR of 8'h01 with 8'h00 gives parity = 1.
- Backpressure: accept an op, then hold out_ready = 0 for 5 cycles while in_valid = 1 with changing operands. Required:
  - in_ready = 0 throughout;
  - y and the flags stay frozen;
  - on out_ready = 1, the next operand is accepted in the same cycle and the old result is delivered exactly once.
- Wrap and width: CNT_W = 2, deliver 5 results; done_cnt steps 1, 2, 3, 0, 1. Repeat the NAND exhaustive check with WIDTH = 1 (inputs 00, 01, 10, 11 give 1, 1, 1, 0) and with WIDTH = 64 (a = all ones, b = all ones gives y = 0, zero = 1).
- Reset mid-stall: with out_valid = 1 and out_ready = 0, pulse rst_n low asynchronously between clock edges. Required:
  - out_valid, y and done_cnt clear immediately;
  - in_ready reads 1;
  - the first result after reset is the next accepted operation, not the discarded one.
